hazard_stall_controller: RTL and testbench

//  Producer side of the EX-stage operand bypass: decides when forwarding cannot cover a hazard.

---
 rtl/hazard_stall_controller.sv | 114 +++++++++++
 tb/tb_hazard_stall_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_controller.sv
// Stall/flush control for the 5-stage RV32I core: load-use interlock, redirect flush,
// and data-memory wait handling with a sticky timeout and saturating perf counters.
module hazard_stall_controller #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_uses_rs1,
    input  logic             i_id_uses_rs2,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_mem_read,
    input  logic             i_ex_redirect,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    output logic             o_pc_stall,
    output logic             o_ifid_stall,
    output logic             o_ifid_flush,
    output logic             o_idex_stall,
    output logic             o_idex_flush,
    output logic             o_exmem_stall,
    output logic             o_memwb_flush,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT - 1);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              mem_wait;
    logic              load_use;

    always_comb begin
        state_d       = state_q;
        o_pc_stall    = 1'b0;
        o_ifid_stall  = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_stall  = 1'b0;
        o_idex_flush  = 1'b0;
        o_exmem_stall = 1'b0;
        o_memwb_flush = 1'b0;

        mem_wait = (state_q == RUN) ? (i_mem_req & ~i_mem_ready) : ~i_mem_ready;
        load_use = i_ex_mem_read && (i_ex_rd_addr != 5'd0) &&
                   ((i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd_addr)) ||
                    (i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd_addr)));

        case (state_q)
            RUN:      if (i_mem_req && !i_mem_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (i_mem_ready)               state_d = RUN;
            default:                                 state_d = RUN;
        endcase

        // A memory wait freezes EX, so redirect/load-use are simply re-seen once it drains.
        if (i_rst) begin
            state_d = RUN;
        end else if (mem_wait) begin
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_stall = 1'b1;
            o_memwb_flush = 1'b1;
        end else if (i_ex_redirect) begin
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
        end else if (load_use) begin
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_flush  = 1'b1;
        end
    end

    always_comb begin
        wait_cnt_d  = '0;
        timeout_d   = timeout_q;
        if (mem_wait) begin
            wait_cnt_d = (wait_cnt_q == WC_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;
            if (wait_cnt_q == WC_MAX) timeout_d = 1'b1;
        end
        stall_cnt_d = (o_pc_stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = (o_ifid_flush && (flush_cnt_q != '1)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign o_mem_timeout = timeout_q;
    assign o_stall_cnt   = stall_cnt_q;
    assign o_flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller: vector table, directed multi-cycle sequences,
// and random stimulus against a cycle-level reference model.
module tb_hazard_stall_controller;
    localparam int MT = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, mr, redir, mreq, mrdy;
    logic o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush;
    logic o_exmem_stall, o_memwb_flush, o_mem_timeout;
    logic [CW-1:0] o_stall_cnt, o_flush_cnt;

    hazard_stall_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_id_uses_rs1(u1), .i_id_uses_rs2(u2),
        .i_ex_rd_addr(rd), .i_ex_mem_read(mr), .i_ex_redirect(redir),
        .i_mem_req(mreq), .i_mem_ready(mrdy),
        .o_pc_stall(o_pc_stall), .o_ifid_stall(o_ifid_stall), .o_ifid_flush(o_ifid_flush),
        .o_idex_stall(o_idex_stall), .o_idex_flush(o_idex_flush),
        .o_exmem_stall(o_exmem_stall), .o_memwb_flush(o_memwb_flush),
        .o_mem_timeout(o_mem_timeout), .o_stall_cnt(o_stall_cnt), .o_flush_cnt(o_flush_cnt)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Output bit order: {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_flush}
    localparam logic [6:0] E_NONE = 7'b0000000;
    localparam logic [6:0] E_WAIT = 7'b1101011;
    localparam logic [6:0] E_REDR = 7'b0010100;
    localparam logic [6:0] E_LU   = 7'b1100100;

    // Reference model state: whether memory is outstanding, length of current wait run,
    // sticky timeout, and plain integer event tallies.
    bit m_waiting, m_to;
    int m_run, m_sc, m_fc;

    function automatic logic [6:0] dut_ctl();
        return {o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
                o_exmem_stall, o_memwb_flush};
    endfunction

    function automatic logic [6:0] model_ctl();
        bit stalled_mem, hazard;
        if (rst) return E_NONE;
        stalled_mem = m_waiting ? !mrdy : (mreq && !mrdy);
        hazard = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (stalled_mem) return E_WAIT;
        if (redir) return E_REDR;
        if (hazard) return E_LU;
        return E_NONE;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, logic [4:0] a1, logic [4:0] a2, bit b1, bit b2,
                         logic [4:0] d, bit m, bit rdr, bit q, bit y);
        rst = r; rs1 = a1; rs2 = a2; u1 = b1; u2 = b2; rd = d;
        mr = m; redir = rdr; mreq = q; mrdy = y;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    // Called at a negedge with inputs applied: compare, advance model, move to next negedge.
    task automatic step(string nm);
        logic [6:0] e;
        #1;
        e = model_ctl();
        chk({nm, "_ctl"}, 32'(dut_ctl()), 32'(e));
        chk({nm, "_to"},  32'(o_mem_timeout), 32'(m_to));
        chk({nm, "_sc"},  32'(o_stall_cnt), 32'(m_sc));
        chk({nm, "_fc"},  32'(o_flush_cnt), 32'(m_fc));
        if (rst) begin
            m_waiting = 0; m_to = 0; m_run = 0; m_sc = 0; m_fc = 0;
        end else begin
            m_waiting = (e == E_WAIT);
            m_run = m_waiting ? m_run + 1 : 0;
            if (m_run >= MT) m_to = 1;
            if (e[6] && m_sc < CMAX) m_sc++;
            if (e[4] && m_fc < CMAX) m_fc++;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst");
        idle();
    endtask

    typedef struct {
        string      nm;
        logic [4:0] a1, a2, d;
        bit         b1, b2, m, rdr, q, y;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        tbl[0]  = '{"lu_rs1",      5, 0, 5, 1, 0, 1, 0, 0, 1, E_LU};
        tbl[1]  = '{"lu_rs2",      1, 7, 7, 0, 1, 1, 0, 0, 1, E_LU};
        tbl[2]  = '{"x0_load",     0, 0, 0, 1, 1, 1, 0, 0, 1, E_NONE};
        tbl[3]  = '{"no_load",     5, 5, 5, 1, 1, 0, 0, 0, 1, E_NONE};
        tbl[4]  = '{"unused_regs", 5, 5, 5, 0, 0, 1, 0, 0, 1, E_NONE};
        tbl[5]  = '{"redirect",    0, 0, 0, 0, 0, 0, 1, 0, 1, E_REDR};
        tbl[6]  = '{"redir_lu",    3, 0, 3, 1, 0, 1, 1, 0, 1, E_REDR};
        tbl[7]  = '{"memwait_lu",  3, 0, 3, 1, 0, 1, 0, 1, 0, E_WAIT};
        tbl[8]  = '{"memrdy_lu",   3, 0, 3, 1, 0, 1, 0, 1, 1, E_LU};
        tbl[9]  = '{"memwait_rd",  0, 0, 0, 0, 0, 0, 1, 1, 0, E_WAIT};
        tbl[10] = '{"quiet",       9, 4, 2, 1, 1, 1, 0, 0, 0, E_NONE};
        tbl[11] = '{"rs2_unused",  1, 6, 6, 1, 0, 1, 0, 0, 1, E_NONE};

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        step("init_rst");
        idle();
        step("post_rst");

        foreach (tbl[i]) begin
            do_reset();
            drive(0, tbl[i].a1, tbl[i].a2, tbl[i].b1, tbl[i].b2, tbl[i].d,
                  tbl[i].m, tbl[i].rdr, tbl[i].q, tbl[i].y);
            #1 chk({"tbl_", tbl[i].nm}, 32'(dut_ctl()), 32'(tbl[i].exp));
            step({"tblm_", tbl[i].nm});
        end

        // Load-use single bubble
        do_reset();
        drive(0, 5, 0, 0, 0, 5, 1, 0, 0, 1); u1 = 1;
        step("t1_lu");
        idle();
        #1 chk("t1_release", 32'(dut_ctl()), 32'(E_NONE));
        chk("t1_stall_cnt", 32'(o_stall_cnt), 32'd1);
        step("t1_after");

        // Three wait cycles then completion
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            #1 chk("t3_wait", 32'(dut_ctl()), 32'(E_WAIT));
            step("t3_waitm");
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1 chk("t3_done", 32'(dut_ctl()), 32'(E_NONE));
        step("t3_donem");
        idle();
        #1 chk("t3_stall_cnt", 32'(o_stall_cnt), 32'd3);
        step("t3_after");

        // Redirect beats load-use
        do_reset();
        drive(0, 4, 0, 1, 0, 4, 1, 1, 0, 1);
        #1 chk("t4_redir", 32'(dut_ctl()), 32'(E_REDR));
        step("t4_redirm");
        idle();
        #1 chk("t4_flush_cnt", 32'(o_flush_cnt), 32'd1);
        chk("t4_stall_cnt", 32'(o_stall_cnt), 32'd0);
        step("t4_after");

        // Timeout after the 4th consecutive wait cycle, sticky afterwards
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            step("t5_wait");
            #1;
            if (k == 3) chk("t5_to_before", 32'(o_mem_timeout), 32'd0);
            if (k == 4) chk("t5_to_rise", 32'(o_mem_timeout), 32'd1);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step("t5_ready");
        idle();
        step("t5_idle");
        #1 chk("t5_sticky", 32'(o_mem_timeout), 32'd1);

        // Reset while in MEM_WAIT; mem_ready low afterwards must not re-stall from RUN
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            step("t6_wait");
        end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        #1 chk("t6_rst_comb", 32'(dut_ctl()), 32'(E_NONE));
        step("t6_rstm");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("t6_no_stall", 32'(dut_ctl()), 32'(E_NONE));
        chk("t6_to", 32'(o_mem_timeout), 32'd0);
        chk("t6_sc", 32'(o_stall_cnt), 32'd0);
        step("t6_after");

        // Counter saturation
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(0, 2, 0, 1, 0, 2, 1, 0, 0, 1);
            step("sat_sc");
        end
        #1 chk("sat_stall_cnt", 32'(o_stall_cnt), 32'(CMAX));
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
            step("sat_fc");
        end
        #1 chk("sat_flush_cnt", 32'(o_flush_cnt), 32'(CMAX));

        // Random stimulus
        do_reset();
        for (int n = 0; n < 500; n++) begin
            drive(($urandom_range(0, 39) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                  1'($urandom), ($urandom_range(0, 4) == 0),
                  1'($urandom), ($urandom_range(0, 9) < 6));
            step("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
